// File: rtl/pattern_pkg.sv
// Shared constants for the LCD test-pattern source: pattern modes, RGB565 colours,
// colour-bar order and the stage-1 decision record.
package pattern_pkg;

  typedef logic [15:0] rgb565_t;

  localparam logic [1:0] MODE_BARS  = 2'd0;
  localparam logic [1:0] MODE_CHECK = 2'd1;
  localparam logic [1:0] MODE_GRID  = 2'd2;
  localparam logic [1:0] MODE_GRAD  = 2'd3;

  localparam rgb565_t WHITE   = 16'hFFFF;
  localparam rgb565_t YELLOW  = 16'hFFE0;
  localparam rgb565_t CYAN    = 16'h07FF;
  localparam rgb565_t GREEN   = 16'h07E0;
  localparam rgb565_t MAGENTA = 16'hF81F;
  localparam rgb565_t RED     = 16'hF800;
  localparam rgb565_t BLUE    = 16'h001F;
  localparam rgb565_t BLACK   = 16'h0000;
  localparam rgb565_t GRID_BG = 16'h0008;

  typedef struct packed {
    logic       active;
    logic       hsync;
    logic       vsync;
    logic [1:0] mode;
    logic [2:0] bar;
    logic       chk;
    logic       grid;
    logic [4:0] gr;
    logic [5:0] gg;
    logic [4:0] gb;
  } dec_t;

  localparam dec_t DEC_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1, default: '0};

  function automatic rgb565_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = WHITE;
      3'd1:    bar_colour = YELLOW;
      3'd2:    bar_colour = CYAN;
      3'd3:    bar_colour = GREEN;
      3'd4:    bar_colour = MAGENTA;
      3'd5:    bar_colour = RED;
      3'd6:    bar_colour = BLUE;
      default: bar_colour = BLACK;
    endcase
  endfunction

endpackage

// File: rtl/frame_start_det.sv
// Detects the vsync falling edge and owns the frame-boundary state (pattern mode, frame counter).
// The *_eff outputs already reflect a frame start happening this cycle.
module frame_start_det
  import pattern_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic [1:0] mode_req,
  output logic [1:0] mode_eff,
  output logic [7:0] frame,
  output logic [7:0] frame_eff
);

  logic       vsync_q;
  logic [1:0] mode_q;
  logic       start;

  // Edge register resets low so a vsync held low across reset release is not a frame start.
  assign start     = vsync_q & ~vsync;
  assign mode_eff  = start ? mode_req : mode_q;
  assign frame_eff = start ? frame + 8'd1 : frame;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= 1'b0;
      mode_q  <= MODE_BARS;
      frame   <= 8'd0;
    end else begin
      vsync_q <= vsync;
      mode_q  <= mode_eff;
      frame   <= frame_eff;
    end
  end

endmodule

// File: rtl/pattern_gen.sv
// RGB565 test-pattern source for the 480x272 LCD; two-stage pipeline (decide, then colour map).
// Syncs and data-enable are delayed alongside the pixel so everything leaves aligned.
module pattern_gen
  import pattern_pkg::*;
#(
  parameter int HACTIVE    = 480,
  parameter int VACTIVE    = 272,
  parameter int BAR_W      = 60,
  parameter int CHECK_LOG2 = 4,
  parameter int GRID_LOG2  = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       hactive_i,
  input  logic       vactive_i,
  input  logic       hsync_i,
  input  logic       vsync_i,
  input  logic [8:0] col_i,
  input  logic [8:0] lin_i,
  input  logic [1:0] mode_i,
  output logic [4:0] r_o,
  output logic [5:0] g_o,
  output logic [4:0] b_o,
  output logic       de_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic [7:0] frame_o
);

  logic [1:0] mode_eff;
  logic [7:0] frame_eff;
  dec_t       dec;
  dec_t       s1;
  rgb565_t    colour;

  frame_start_det u_fsd (
    .clk       (clk_i),
    .rst       (rst_i),
    .vsync     (vsync_i),
    .mode_req  (mode_i),
    .mode_eff  (mode_eff),
    .frame     (frame_o),
    .frame_eff (frame_eff)
  );

  always_comb begin
    dec        = DEC_IDLE;
    dec.active = hactive_i & vactive_i;
    dec.hsync  = hsync_i;
    dec.vsync  = vsync_i;
    dec.mode   = mode_eff;
    // Bar index as a compare chain rather than a divider.
    for (int k = 1; k < 8; k++) begin
      if (int'(col_i) >= k * BAR_W) dec.bar = 3'(k);
    end
    dec.chk  = 1'((col_i + 9'(frame_eff)) >> CHECK_LOG2) ^ lin_i[CHECK_LOG2];
    dec.grid = (col_i[GRID_LOG2-1:0] == '0) || (lin_i[GRID_LOG2-1:0] == '0) ||
               (col_i == 9'(HACTIVE - 1)) || (lin_i == 9'(VACTIVE - 1));
    dec.gr   = col_i[8:4];
    dec.gg   = lin_i[8:3];
    dec.gb   = frame_eff[7:3];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) s1 <= DEC_IDLE;
    else       s1 <= dec;
  end

  always_comb begin
    colour = BLACK;
    case (s1.mode)
      MODE_BARS:  colour = bar_colour(s1.bar);
      MODE_CHECK: colour = s1.chk ? WHITE : BLACK;
      MODE_GRID:  colour = s1.grid ? WHITE : GRID_BG;
      default:    colour = {s1.gr, s1.gg, s1.gb};
    endcase
    if (!s1.active) colour = BLACK;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_o     <= '0;
      g_o     <= '0;
      b_o     <= '0;
      de_o    <= 1'b0;
      hsync_o <= 1'b1;
      vsync_o <= 1'b1;
    end else begin
      {r_o, g_o, b_o} <= colour;
      de_o            <= s1.active;
      hsync_o         <= s1.hsync;
      vsync_o         <= s1.vsync;
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: bars sweep, blanking/sync delay, frame-boundary mode
// latching, scrolling checker, frame counter wrap, gradient and mid-frame reset.
module tb_pattern_gen;

  logic       clk_i = 1'b0;
  logic       rst_i, hactive_i, vactive_i, hsync_i, vsync_i;
  logic [8:0] col_i, lin_i;
  logic [1:0] mode_i;
  logic [4:0] r_o;
  logic [5:0] g_o;
  logic [4:0] b_o;
  logic       de_o, hsync_o, vsync_o;
  logic [7:0] frame_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] bar_tab [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                               16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  pattern_gen dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .hactive_i (hactive_i),
    .vactive_i (vactive_i),
    .hsync_i   (hsync_i),
    .vsync_i   (vsync_i),
    .col_i     (col_i),
    .lin_i     (lin_i),
    .mode_i    (mode_i),
    .r_o       (r_o),
    .g_o       (g_o),
    .b_o       (b_o),
    .de_o      (de_o),
    .hsync_o   (hsync_o),
    .vsync_o   (vsync_o),
    .frame_o   (frame_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] rgb();
    return {16'd0, r_o, g_o, b_o};
  endfunction

  // Hold one pixel through both pipeline stages, then check colour and data-enable.
  task automatic px(input string tag, input int c, input int l, input logic [15:0] exp);
    col_i = c[8:0];
    lin_i = l[8:0];
    tick();
    tick();
    chk(tag, rgb(), {16'd0, exp});
    chk({tag, "_de"}, {31'd0, de_o}, 32'd1);
  endtask

  task automatic fstart();
    vsync_i = 1'b0;
    tick();
    vsync_i = 1'b1;
    tick();
  endtask

  initial begin
    rst_i = 1'b1; hactive_i = 1'b1; vactive_i = 1'b1;
    hsync_i = 1'b1; vsync_i = 1'b1;
    col_i = '0; lin_i = 9'd10; mode_i = 2'd0;
    tick();
    tick();
    chk("rst_rgb",   rgb(), 32'd0);
    chk("rst_de",    {31'd0, de_o}, 32'd0);
    chk("rst_hsync", {31'd0, hsync_o}, 32'd1);
    chk("rst_vsync", {31'd0, vsync_o}, 32'd1);
    chk("rst_frame", {24'd0, frame_o}, 32'd0);

    // Colour-bar sweep on line 10; output after each tick belongs to the previous column.
    rst_i = 1'b0;
    for (int c = 0; c <= 480; c++) begin
      if (c < 480) col_i = c[8:0];
      tick();
      if (c >= 1) begin
        chk($sformatf("bars_c%0d", c - 1), rgb(), {16'd0, bar_tab[(c - 1) / 60]});
        chk($sformatf("bars_de%0d", c - 1), {31'd0, de_o}, 32'd1);
      end
    end
    px("bars_c0", 0, 10, 16'hFFFF);
    px("bars_c60", 60, 10, 16'hFFE0);
    px("bars_c479", 479, 10, 16'h0000);

    // Blanking and hsync both take exactly two cycles to reach the outputs.
    px("blank_pre", 100, 10, 16'hFFE0);
    hactive_i = 1'b0; hsync_i = 1'b0;
    tick();
    chk("blank_d1_rgb", rgb(), 32'h0000FFE0);
    chk("blank_d1_de",  {31'd0, de_o}, 32'd1);
    chk("hs_d1",        {31'd0, hsync_o}, 32'd1);
    tick();
    chk("blank_d2_rgb", rgb(), 32'd0);
    chk("blank_d2_de",  {31'd0, de_o}, 32'd0);
    chk("hs_d2",        {31'd0, hsync_o}, 32'd0);
    hactive_i = 1'b1; hsync_i = 1'b1;
    tick();
    chk("hs_rise_d1", {31'd0, hsync_o}, 32'd0);
    tick();
    chk("hs_rise_d2", {31'd0, hsync_o}, 32'd1);

    // Mode request mid-frame waits for the next vsync falling edge.
    mode_i = 2'd2;
    px("midframe_bars", 1, 100, 16'hFFFF);
    fstart();
    chk("frame_1", {24'd0, frame_o}, 32'd1);
    px("grid_c0",   0,   100, 16'hFFFF);
    px("grid_c32",  32,  100, 16'hFFFF);
    px("grid_c479", 479, 100, 16'hFFFF);
    px("grid_c1",   1,   100, 16'h0008);
    px("grid_l271", 5,   271, 16'hFFFF);

    // Scrolling checker: column boundary moves left by one pixel per frame.
    mode_i = 2'd1;
    fstart();
    chk("frame_2", {24'd0, frame_o}, 32'd2);
    px("chk_f2_c13", 13, 0, 16'h0000);
    px("chk_f2_c14", 14, 0, 16'hFFFF);
    fstart();
    chk("frame_3", {24'd0, frame_o}, 32'd3);
    px("chk_f3_c12", 12, 0, 16'h0000);
    px("chk_f3_c13", 13, 0, 16'hFFFF);
    px("chk_f3_l16", 12, 16, 16'hFFFF);

    // Gradient at the last pixel with the counter at its top value.
    mode_i = 2'd3;
    for (int n = 0; n < 252; n++) fstart();
    chk("frame_255", {24'd0, frame_o}, 32'd255);
    px("grad_max", 479, 271, {5'd29, 6'd33, 5'd31});

    mode_i = 2'd1;
    fstart();
    chk("frame_wrap", {24'd0, frame_o}, 32'd0);
    px("chk_f0_c15", 15, 0, 16'h0000);
    px("chk_f0_c16", 16, 0, 16'hFFFF);
    fstart();
    chk("frame_1b", {24'd0, frame_o}, 32'd1);
    px("chk_f1_c15", 15, 0, 16'hFFFF);
    px("chk_f1_c14", 14, 0, 16'h0000);

    // One-cycle reset mid-line with vsync low: no spurious frame start afterwards.
    mode_i = 2'd2;
    fstart();
    px("pre_rst_grid", 1, 100, 16'h0008);
    rst_i = 1'b1; vsync_i = 1'b0;
    tick();
    chk("mrst_rgb",   rgb(), 32'd0);
    chk("mrst_de",    {31'd0, de_o}, 32'd0);
    chk("mrst_hsync", {31'd0, hsync_o}, 32'd1);
    chk("mrst_vsync", {31'd0, vsync_o}, 32'd1);
    chk("mrst_frame", {24'd0, frame_o}, 32'd0);
    rst_i = 1'b0;
    tick();
    tick();
    chk("post_rst_rgb",   rgb(), 32'h0000FFFF);
    chk("post_rst_vsync", {31'd0, vsync_o}, 32'd0);
    tick();
    chk("post_rst_frame", {24'd0, frame_o}, 32'd0);
    vsync_i = 1'b1;
    tick();
    chk("vs_high_frame", {24'd0, frame_o}, 32'd0);
    vsync_i = 1'b0;
    tick();
    chk("vs_fall_frame", {24'd0, frame_o}, 32'd1);
    vsync_i = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
